// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: registered decode, one-entry skid buffer, flush.
// Define RV32I_DECODE_ILLEGAL_CHECK_EN to flag undefined encodings on o_out_illegal.
module rv32i_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_in_inst,
  input  logic [XLEN-1:0] i_in_pc,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_pc,
  output logic [4:0]      o_out_rs1,
  output logic [4:0]      o_out_rs2,
  output logic [4:0]      o_out_rd,
  output logic [XLEN-1:0] o_out_imm,
  output logic [2:0]      o_out_funct3,
  output logic [3:0]      o_out_alu_op,
  output logic            o_out_alu_src_imm,
  output logic            o_out_alu_src_pc,
  output logic            o_out_reg_wr,
  output logic            o_out_mem_rd,
  output logic            o_out_mem_wr,
  output logic            o_out_branch,
  output logic            o_out_jump,
  output logic            o_out_illegal
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    alu_op_e         alu_op;
    logic            alu_src_imm;
    logic            alu_src_pc;
    logic            reg_wr;
    logic            mem_rd;
    logic            mem_wr;
    logic            branch;
    logic            jump;
    logic            illegal;
  } bundle_t;

  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic            w_illegal;
  logic            w_accept;
  logic            w_out_free;
  bundle_t         w_dec;
  bundle_t         r_out, r_skid;
  logic            r_out_valid, r_skid_valid;

  assign w_opcode = i_in_inst[6:0];
  assign w_funct3 = i_in_inst[14:12];
  assign w_imm_i  = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
  assign w_imm_s  = {{20{i_in_inst[31]}}, i_in_inst[31:25], i_in_inst[11:7]};
  assign w_imm_b  = {{19{i_in_inst[31]}}, i_in_inst[31], i_in_inst[7],
                     i_in_inst[30:25], i_in_inst[11:8], 1'b0};
  assign w_imm_u  = {i_in_inst[31:12], 12'h000};
  assign w_imm_j  = {{11{i_in_inst[31]}}, i_in_inst[31], i_in_inst[19:12],
                     i_in_inst[20], i_in_inst[30:21], 1'b0};

`ifdef RV32I_DECODE_ILLEGAL_CHECK_EN
  logic [6:0] w_funct7;
  assign w_funct7 = i_in_inst[31:25];

  // The all-zero word is a bubble, never illegal.
  always_comb begin
    w_illegal = 1'b0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: w_illegal = 1'b0;
      OPC_JALR:   w_illegal = (w_funct3 != 3'b000);
      OPC_BRANCH: w_illegal = (w_funct3 inside {3'b010, 3'b011});
      OPC_LOAD:   w_illegal = (w_funct3 inside {3'b011, 3'b110, 3'b111});
      OPC_STORE:  w_illegal = (w_funct3 > 3'b010);
      OPC_OP_IMM: begin
        if (w_funct3 == 3'b001)      w_illegal = (w_funct7 != 7'h00);
        else if (w_funct3 == 3'b101) w_illegal = !(w_funct7 inside {7'h00, 7'h20});
      end
      OPC_OP: w_illegal = !((w_funct7 == 7'h00) ||
                            (w_funct7 == 7'h20 && (w_funct3 inside {3'b000, 3'b101})));
      default: w_illegal = (i_in_inst != 32'h0000_0000);
    endcase
  end
`else
  assign w_illegal = 1'b0;
`endif

  // NOTE: every field gets a default first so no path through the case infers a latch.
  always_comb begin
    w_dec        = '0;
    w_dec.pc     = i_in_pc;
    w_dec.funct3 = w_funct3;
    case (w_opcode)
      OPC_OP: begin
        w_dec.rs1    = i_in_inst[19:15];
        w_dec.rs2    = i_in_inst[24:20];
        w_dec.rd     = i_in_inst[11:7];
        w_dec.alu_op = alu_from_funct(w_funct3, i_in_inst[30]);
        w_dec.reg_wr = 1'b1;
      end
      OPC_OP_IMM: begin
        w_dec.rs1         = i_in_inst[19:15];
        w_dec.rd          = i_in_inst[11:7];
        w_dec.alu_op      = alu_from_funct(w_funct3, (w_funct3 == 3'b101) && i_in_inst[30]);
        w_dec.alu_src_imm = 1'b1;
        w_dec.reg_wr      = 1'b1;
        w_dec.imm         = (w_funct3 inside {3'b001, 3'b101}) ?
                            {{(XLEN-5){1'b0}}, i_in_inst[24:20]} : w_imm_i;
      end
      OPC_LUI: begin
        w_dec.rd = i_in_inst[11:7]; w_dec.imm = w_imm_u; w_dec.alu_op = ALU_PASSB;
        w_dec.alu_src_imm = 1'b1; w_dec.reg_wr = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.rd = i_in_inst[11:7]; w_dec.imm = w_imm_u; w_dec.alu_op = ALU_ADD;
        w_dec.alu_src_imm = 1'b1; w_dec.alu_src_pc = 1'b1; w_dec.reg_wr = 1'b1;
      end
      OPC_LOAD: begin
        w_dec.rs1 = i_in_inst[19:15]; w_dec.rd = i_in_inst[11:7]; w_dec.imm = w_imm_i;
        w_dec.alu_src_imm = 1'b1; w_dec.reg_wr = 1'b1; w_dec.mem_rd = 1'b1;
      end
      OPC_STORE: begin
        w_dec.rs1 = i_in_inst[19:15]; w_dec.rs2 = i_in_inst[24:20]; w_dec.imm = w_imm_s;
        w_dec.alu_src_imm = 1'b1; w_dec.mem_wr = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.rs1 = i_in_inst[19:15]; w_dec.rs2 = i_in_inst[24:20]; w_dec.imm = w_imm_b;
        w_dec.alu_op = ALU_SUB; w_dec.branch = 1'b1;
      end
      OPC_JAL: begin
        w_dec.rd = i_in_inst[11:7]; w_dec.imm = w_imm_j; w_dec.alu_src_imm = 1'b1;
        w_dec.alu_src_pc = 1'b1; w_dec.jump = 1'b1; w_dec.reg_wr = 1'b1;
      end
      OPC_JALR: begin
        w_dec.rs1 = i_in_inst[19:15]; w_dec.rd = i_in_inst[11:7]; w_dec.imm = w_imm_i;
        w_dec.alu_src_imm = 1'b1; w_dec.jump = 1'b1; w_dec.reg_wr = 1'b1;
      end
      default: w_dec.funct3 = 3'b000;
    endcase
    if (w_dec.rd == 5'd0) w_dec.reg_wr = 1'b0;
    if (w_illegal) begin
      w_dec         = '0;
      w_dec.pc      = i_in_pc;
      w_dec.illegal = 1'b1;
    end
  end

  assign o_in_ready = !r_skid_valid;
  assign w_accept   = i_in_valid && o_in_ready && !i_flush;
  assign w_out_free = !r_out_valid || i_out_ready;

  // NOTE: the bundle registers are reset as well, so every o_out_* reads 0 after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (i_flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      // NOTE: non-blocking assignments let skid->out and the skid clear share one edge.
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) r_out <= w_dec;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign o_out_valid       = r_out_valid;
  assign o_out_pc          = r_out.pc;
  assign o_out_rs1         = r_out.rs1;
  assign o_out_rs2         = r_out.rs2;
  assign o_out_rd          = r_out.rd;
  assign o_out_imm         = r_out.imm;
  assign o_out_funct3      = r_out.funct3;
  assign o_out_alu_op      = r_out.alu_op;
  assign o_out_alu_src_imm = r_out.alu_src_imm;
  assign o_out_alu_src_pc  = r_out.alu_src_pc;
  assign o_out_reg_wr      = r_out.reg_wr;
  assign o_out_mem_rd      = r_out.mem_rd;
  assign o_out_mem_wr      = r_out.mem_wr;
  assign o_out_branch      = r_out.branch;
  assign o_out_jump        = r_out.jump;
  assign o_out_illegal     = r_out.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Testbench for rv32i_decode_stage: table of hand-decoded instructions fed through a
// scoreboard, plus backpressure, flush and mid-stream reset sequences.
module tb_rv32i_decode_stage;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [7:0]  flags; // {src_imm, src_pc, reg_wr, mem_rd, mem_wr, branch, jump, illegal}
  } vec_t;

`ifdef RV32I_DECODE_ILLEGAL_CHECK_EN
  localparam logic [7:0] ILL_FLAGS = 8'h01;
`else
  localparam logic [7:0] ILL_FLAGS = 8'h00;
`endif
  localparam int NVEC = 15;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3;
  logic [3:0]  out_alu_op;
  logic        src_imm, src_pc, reg_wr, mem_rd, mem_wr, branch, jump, illegal;
  logic [7:0]  out_flags;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  vec_t vecs[NVEC];
  vec_t sb[$];
  vec_t cur;
  vec_t popped;

  always #5 clk = ~clk;

  rv32i_decode_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_inst(in_inst), .i_in_pc(in_pc),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_pc(out_pc),
    .o_out_rs1(out_rs1), .o_out_rs2(out_rs2), .o_out_rd(out_rd), .o_out_imm(out_imm),
    .o_out_funct3(out_funct3), .o_out_alu_op(out_alu_op),
    .o_out_alu_src_imm(src_imm), .o_out_alu_src_pc(src_pc), .o_out_reg_wr(reg_wr),
    .o_out_mem_rd(mem_rd), .o_out_mem_wr(mem_wr), .o_out_branch(branch),
    .o_out_jump(jump), .o_out_illegal(illegal)
  );

  assign out_flags = {src_imm, src_pc, reg_wr, mem_rd, mem_wr, branch, jump, illegal};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] pc,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] imm,
                              input logic [2:0] f3, input logic [3:0] alu,
                              input logic [7:0] flags);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.imm = imm; v.f3 = f3; v.alu = alu; v.flags = flags;
    return v;
  endfunction

  // Scoreboard: pop and compare on each output handshake, push on each accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got pc 0x%0h, want no output", out_pc);
        end else begin
          popped = sb.pop_front();
          n_out++;
          check($sformatf("pc@%08h",  popped.inst), 64'(out_pc),     64'(popped.pc));
          check($sformatf("rs1@%08h", popped.inst), 64'(out_rs1),    64'(popped.rs1));
          check($sformatf("rs2@%08h", popped.inst), 64'(out_rs2),    64'(popped.rs2));
          check($sformatf("rd@%08h",  popped.inst), 64'(out_rd),     64'(popped.rd));
          check($sformatf("imm@%08h", popped.inst), 64'(out_imm),    64'(popped.imm));
          check($sformatf("f3@%08h",  popped.inst), 64'(out_funct3), 64'(popped.f3));
          check($sformatf("alu@%08h", popped.inst), 64'(out_alu_op), 64'(popped.alu));
          check($sformatf("flags@%08h", popped.inst), 64'(out_flags), 64'(popped.flags));
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(cur);
    end
  end

  // Drive one instruction and hold it until accepted (bounded wait).
  task automatic send(input vec_t v);
    int waited = 0;
    in_valid = 1'b1; in_inst = v.inst; in_pc = v.pc; cur = v;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 for %0d cycles, want 1", waited);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want end before 200000");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(32'h00100213, 32'h04, 5'd0, 5'd0, 5'd4, 32'h1,        3'd0, 4'd0,  8'hA0); // ADDI x4,x0,1
    vecs[1]  = mk(32'h00520333, 32'h08, 5'd4, 5'd5, 5'd6, 32'h0,        3'd0, 4'd0,  8'h20); // ADD
    vecs[2]  = mk(32'h40520333, 32'h0C, 5'd4, 5'd5, 5'd6, 32'h0,        3'd0, 4'd1,  8'h20); // SUB
    vecs[3]  = mk(32'hFE000CE3, 32'h10, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 3'd0, 4'd1,  8'h04); // BEQ -8
    vecs[4]  = mk(32'h123450B7, 32'h14, 5'd0, 5'd0, 5'd1, 32'h12345000, 3'd5, 4'd10, 8'hA0); // LUI
    vecs[5]  = mk(32'h00512423, 32'h18, 5'd2, 5'd5, 5'd0, 32'h8,        3'd2, 4'd0,  8'h88); // SW
    vecs[6]  = mk(32'hFFC1A383, 32'h1C, 5'd3, 5'd0, 5'd7, 32'hFFFFFFFC, 3'd2, 4'd0,  8'hB0); // LW -4
    vecs[7]  = mk(32'h40345493, 32'h20, 5'd8, 5'd0, 5'd9, 32'h3,        3'd5, 4'd7,  8'hA0); // SRAI
    vecs[8]  = mk(32'h00508013, 32'h24, 5'd1, 5'd0, 5'd0, 32'h5,        3'd0, 4'd0,  8'h80); // ADDI x0
    vecs[9]  = mk(32'h010000EF, 32'h28, 5'd0, 5'd0, 5'd1, 32'h10,       3'd0, 4'd0,  8'hE2); // JAL
    vecs[10] = mk(32'h00001297, 32'h2C, 5'd0, 5'd0, 5'd5, 32'h1000,     3'd1, 4'd0,  8'hE0); // AUIPC
    vecs[11] = mk(32'h00008067, 32'h30, 5'd1, 5'd0, 5'd0, 32'h0,        3'd0, 4'd0,  8'h82); // JALR x0
    vecs[12] = mk(32'h00000000, 32'h34, 5'd0, 5'd0, 5'd0, 32'h0,        3'd0, 4'd0,  8'h00); // bubble
    vecs[13] = mk(32'h0000007F, 32'h38, 5'd0, 5'd0, 5'd0, 32'h0,        3'd0, 4'd0,  ILL_FLAGS);
    vecs[14] = mk(32'h0020C1B3, 32'h3C, 5'd1, 5'd2, 5'd3, 32'h0,        3'd4, 4'd5,  8'h20); // XOR

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_pc",        64'(out_pc),    64'd0);
    check("reset_imm",       64'(out_imm),   64'd0);
    check("reset_fields",    64'({out_rs1, out_rs2, out_rd, out_funct3, out_alu_op}), 64'd0);
    check("reset_flags",     64'(out_flags), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-throughput table stream; first item also checks 1-cycle latency.
    send(vecs[0]);
    check("latency_1cycle", 64'(out_valid), 64'd1);
    for (int i = 1; i < NVEC; i++) send(vecs[i]);
    repeat (3) @(posedge clk); #1;
    check("table_outputs", 64'(n_out), 64'(NVEC));

    // Backpressure: out_ready low for 3 cycles while streaming 4 instructions.
    fork
      begin
        for (int i = 0; i < 4; i++) send(vecs[i]);
      end
      begin
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready_low", 64'(in_ready), 64'd0);
        check("stall_hold_pc",      64'(out_pc),   64'(vecs[0].pc));
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    check("stall_outputs", 64'(n_out),     64'(NVEC + 4));
    check("stall_sb_empty", 64'(sb.size()), 64'd0);

    // Flush with output and skid registers full and a new input offered.
    out_ready = 1'b0;
    send(vecs[5]);
    send(vecs[6]);
    @(negedge clk);
    check("flush_pre_skid_full", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_inst = vecs[7].inst; in_pc = vecs[7].pc; cur = vecs[7];
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("flush_no_output", 64'(n_out), 64'(NVEC + 4));

    // Reset asserted with both entries held.
    out_ready = 1'b0;
    send(vecs[1]);
    send(vecs[2]);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_pc",        64'(out_pc),    64'd0);
    check("midrst_imm",       64'(out_imm),   64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("midrst_no_output", 64'(n_out), 64'(NVEC + 4));
    send(vecs[4]);
    repeat (2) @(posedge clk); #1;
    check("post_reset_output", 64'(n_out), 64'(NVEC + 5));
    check("end_sb_empty",      64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
